// File: rtl/nn_pkg.sv
// nn_pkg: shared fixed-point width and FSM state encoding
// for the layer sequencer, plus an address-width helper.
package nn_pkg;

  localparam int Q_WIDTH = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_STREAM,
    S_WAIT,
    S_DONE
  } seq_state_e;

  function automatic int addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/layer_sequencer_if.sv
// layer_sequencer_if: RAM, neuron and result bundle of the
// sequencer. master = sequencer side, slave = environment.
interface layer_sequencer_if
  import nn_pkg::*;
#(
  parameter int IN_WIDTH    = Q_WIDTH,
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_NEURONS = 10,
  parameter int OUT_WIDTH   = Q_WIDTH
);

  localparam int PAW = addr_w(NUM_INPUTS);
  localparam int WAW = addr_w(NUM_INPUTS * NUM_NEURONS);
  localparam int NAW = addr_w(NUM_NEURONS);

  logic                 start;
  logic                 busy;
  logic                 done;
  logic [PAW-1:0]       pix_addr;
  logic [IN_WIDTH-1:0]  pix_data;
  logic [WAW-1:0]       w_addr;
  logic [IN_WIDTH-1:0]  w_data;
  logic [NAW-1:0]       b_addr;
  logic [IN_WIDTH-1:0]  b_data;
  logic                 neuron_clr;
  logic [IN_WIDTH-1:0]  data_in;
  logic [IN_WIDTH-1:0]  weight_in;
  logic [IN_WIDTH-1:0]  bias_in;
  logic                 input_valid;
  logic [OUT_WIDTH-1:0] neuron_out;
  logic                 neuron_valid;
  logic                 res_we;
  logic [NAW-1:0]       res_addr;
  logic [OUT_WIDTH-1:0] res_data;

  modport master (
    input  start,
    input  pix_data,
    input  w_data,
    input  b_data,
    input  neuron_out,
    input  neuron_valid,
    output busy,
    output done,
    output pix_addr,
    output w_addr,
    output b_addr,
    output neuron_clr,
    output data_in,
    output weight_in,
    output bias_in,
    output input_valid,
    output res_we,
    output res_addr,
    output res_data
  );

  modport slave (
    output start,
    output pix_data,
    output w_data,
    output b_data,
    output neuron_out,
    output neuron_valid,
    input  busy,
    input  done,
    input  pix_addr,
    input  w_addr,
    input  b_addr,
    input  neuron_clr,
    input  data_in,
    input  weight_in,
    input  bias_in,
    input  input_valid,
    input  res_we,
    input  res_addr,
    input  res_data
  );

endinterface

// File: rtl/addr_gen.sv
// addr_gen: input index i and neuron index n counters.
// i_i_en/i_n_en step, i_n_clr zeroes n; o_base = n*NUM_INPUTS.
module addr_gen
  import nn_pkg::*;
#(
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_NEURONS = 10,
  localparam int IAW = addr_w(NUM_INPUTS),
  localparam int NAW = addr_w(NUM_NEURONS),
  localparam int WAW = addr_w(NUM_INPUTS * NUM_NEURONS)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_i_en,
  input  logic           i_n_clr,
  input  logic           i_n_en,
  output logic [IAW-1:0] o_i,
  output logic [NAW-1:0] o_n,
  output logic [WAW-1:0] o_base,
  output logic           o_i_last,
  output logic           o_n_last
);

  logic [IAW-1:0] r_i;
  logic [NAW-1:0] r_n;
  logic [WAW-1:0] r_base;

  assign o_i      = r_i;
  assign o_n      = r_n;
  assign o_base   = r_base;
  assign o_i_last = (r_i == IAW'(NUM_INPUTS - 1));
  assign o_n_last = (r_n == NAW'(NUM_NEURONS - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_i <= '0;
    end else if (i_i_en) begin
      r_i <= o_i_last ? '0 : r_i + IAW'(1);
    end
  end

  // r_base tracks n*NUM_INPUTS incrementally: no multiplier,
  // and it never exceeds (NUM_NEURONS-1)*NUM_INPUTS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_n    <= '0;
      r_base <= '0;
    end else if (i_n_clr) begin
      r_n    <= '0;
      r_base <= '0;
    end else if (i_n_en) begin
      if (o_n_last) begin
        r_n    <= '0;
        r_base <= '0;
      end else begin
        r_n    <= r_n + NAW'(1);
        r_base <= r_base + WAW'(NUM_INPUTS);
      end
    end
  end

endmodule

// File: rtl/layer_sequencer.sv
// layer_sequencer: streams pixels/weights of each neuron into a
// MAC neuron and stores its results. Ports: clk, rst, bus(master).
module layer_sequencer
  import nn_pkg::*;
#(
  parameter int IN_WIDTH    = Q_WIDTH,
  parameter int NUM_INPUTS  = 784,
  parameter int NUM_NEURONS = 10,
  parameter int OUT_WIDTH   = Q_WIDTH,
  localparam int IAW = addr_w(NUM_INPUTS),
  localparam int NAW = addr_w(NUM_NEURONS),
  localparam int WAW = addr_w(NUM_INPUTS * NUM_NEURONS)
) (
  input  logic              clk,
  input  logic              rst,
  layer_sequencer_if.master bus
);

  seq_state_e r_state;
  seq_state_e w_next;

  logic                 w_issue;
  logic                 w_n_clr;
  logic                 w_n_en;
  logic                 w_clr;
  logic                 w_res_we;
  logic                 w_done;
  logic [IAW-1:0]       w_i;
  logic [NAW-1:0]       w_n;
  logic [WAW-1:0]       w_base;
  logic                 w_i_last;
  logic                 w_n_last;
  logic [OUT_WIDTH-1:0] w_res_data;

  logic                r_valid;
  logic [IN_WIDTH-1:0] r_bias;

  addr_gen #(
    .NUM_INPUTS  (NUM_INPUTS),
    .NUM_NEURONS (NUM_NEURONS)
  ) u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .i_i_en   (w_issue),
    .i_n_clr  (w_n_clr),
    .i_n_en   (w_n_en),
    .o_i      (w_i),
    .o_n      (w_n),
    .o_base   (w_base),
    .o_i_last (w_i_last),
    .o_n_last (w_n_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next   = r_state;
    w_issue  = 1'b0;
    w_n_clr  = 1'b0;
    w_n_en   = 1'b0;
    w_clr    = 1'b0;
    w_res_we = 1'b0;
    w_done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_n_clr = 1'b1;
          w_next  = S_LOAD;
        end
      end
      S_LOAD: begin
        w_clr  = 1'b1;
        w_next = S_STREAM;
      end
      S_STREAM: begin
        w_issue = 1'b1;
        if (w_i_last) begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.neuron_valid) begin
          w_res_we = 1'b1;
          if (w_n_last) begin
            w_next = S_DONE;
          end else begin
            w_n_en = 1'b1;
            w_next = S_LOAD;
          end
        end
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // RAM data lands one cycle after the issue, so the beat strobe
  // is the issue strobe delayed by one register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= w_issue;
    end
  end

  // b_addr was presented during LOAD; its data arrives on the
  // first STREAM cycle (i still 0).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bias <= '0;
    end else if (r_state == S_STREAM && w_i == '0) begin
      r_bias <= bus.b_data;
    end
  end

  assign w_res_data = bus.neuron_out;

  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = w_done;
  assign bus.pix_addr    = w_i;
  assign bus.w_addr      = w_base + WAW'(w_i);
  assign bus.b_addr      = w_n;
  assign bus.neuron_clr  = w_clr;
  assign bus.data_in     = bus.pix_data;
  assign bus.weight_in   = bus.w_data;
  assign bus.bias_in     = r_bias;
  assign bus.input_valid = r_valid;
  assign bus.res_we      = w_res_we;
  assign bus.res_addr    = w_n;
  assign bus.res_data    = w_res_data;

endmodule

// File: tb/tb_layer_sequencer.sv
// tb_layer_sequencer: random RAM contents and neuron tokens,
// checked against a cycle/dot-product reference model.
module tb_layer_sequencer;

  localparam int NI = 4;
  localparam int NN = 2;
  localparam int IW = 16;
  localparam int OW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  layer_sequencer_if #(
    .IN_WIDTH    (IW),
    .NUM_INPUTS  (NI),
    .NUM_NEURONS (NN),
    .OUT_WIDTH   (OW)
  ) bus ();

  layer_sequencer #(
    .IN_WIDTH    (IW),
    .NUM_INPUTS  (NI),
    .NUM_NEURONS (NN),
    .OUT_WIDTH   (OW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [IW-1:0] pix_mem [NI];
  logic [IW-1:0] w_mem   [NI*NN];
  logic [IW-1:0] b_mem   [NN];

  always @(posedge clk) begin
    bus.pix_data <= pix_mem[bus.pix_addr];
    bus.w_data   <= w_mem[bus.w_addr];
    bus.b_data   <= b_mem[bus.b_addr];
  end

  int n_checks = 0;
  int n_fail   = 0;

  int load_q[$];
  int ldb_q[$];
  int iv_q[$];
  int wa_q[$];
  int pa_q[$];
  int bias_q[$];
  int we_q[$];
  int ra_q[$];
  int rd_q[$];
  int done_q[$];
  int unsigned acc[NN];
  logic [OW-1:0] tok[NN];
  bit timeout;
  int end_cyc;

  function automatic int unsigned ref_dot(input int n);
    int unsigned s = 0;
    for (int i = 0; i < NI; i++)
      s += 32'(pix_mem[i]) * 32'(w_mem[n*NI+i]);
    return s;
  endfunction

  // LOAD cycle of neuron n, NI+3+d cycles per neuron
  function automatic int ld_cyc(input int n, input int d);
    return 1 + n * (NI + 3 + d);
  endfunction

  // Drives one pass and records events; cycle 0 carries start.
  task automatic run_pass(input int d, input int rs_cyc,
                          input int sp_cyc, input int ab_cyc);
    int c;
    int beats;
    int last_beat;
    int pw;
    int pp;
    for (int i = 0; i < NI; i++) pix_mem[i] = 16'($urandom);
    for (int i = 0; i < NI*NN; i++) w_mem[i] = 16'($urandom);
    for (int n = 0; n < NN; n++) begin
      b_mem[n] = 16'($urandom) | 16'h1;
      tok[n]   = 16'($urandom);
      acc[n]   = 0;
    end
    load_q.delete(); ldb_q.delete(); iv_q.delete();
    wa_q.delete(); pa_q.delete(); bias_q.delete();
    we_q.delete(); ra_q.delete(); rd_q.delete();
    done_q.delete();
    timeout = 1'b0;
    beats = 0;
    last_beat = -1000;
    pw = 0;
    pp = 0;
    c = 0;
    @(posedge clk); #1;
    while (1) begin
      bus.start = (c == 0) || (c == rs_cyc);
      bus.neuron_valid = 1'b0;
      bus.neuron_out = 16'hBEEF;
      if (beats > 0 && c == last_beat + 1 + d) begin
        bus.neuron_valid = 1'b1;
        bus.neuron_out = tok[(beats-1)/NI];
      end
      if (c == sp_cyc) begin
        bus.neuron_valid = 1'b1;
        bus.neuron_out = 16'h0123;
      end
      if (c == ab_cyc) begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.neuron_valid = 1'b0;
        end_cyc = c;
        return;
      end
      @(negedge clk);
      if (bus.neuron_clr) begin
        load_q.push_back(c);
        ldb_q.push_back(int'(bus.b_addr));
      end
      if (bus.input_valid) begin
        iv_q.push_back(c);
        wa_q.push_back(pw);
        pa_q.push_back(pp);
        bias_q.push_back(int'(bus.bias_in));
        if (beats / NI < NN)
          acc[beats/NI] += 32'(bus.data_in) * 32'(bus.weight_in);
        beats++;
        if (beats % NI == 0) last_beat = c;
      end
      if (bus.res_we) begin
        we_q.push_back(c);
        ra_q.push_back(int'(bus.res_addr));
        rd_q.push_back(int'(bus.res_data));
      end
      if (bus.done) done_q.push_back(c);
      pw = int'(bus.w_addr);
      pp = int'(bus.pix_addr);
      if (done_q.size() > 0 && c >= done_q[0] + 3) break;
      if (c >= 400) begin
        timeout = 1'b1;
        break;
      end
      @(posedge clk); #1;
      c++;
    end
    end_cyc = c;
    bus.start = 1'b0;
    bus.neuron_valid = 1'b0;
  endtask

  task automatic test_reset();
    int got[10];
    rst = 1'b1;
    bus.start = 1'b0;
    bus.neuron_valid = 1'b0;
    bus.neuron_out = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    got = '{int'(bus.busy), int'(bus.done),
            int'(bus.input_valid), int'(bus.neuron_clr),
            int'(bus.res_we), int'(bus.bias_in),
            int'(bus.pix_addr), int'(bus.w_addr),
            int'(bus.b_addr), int'(bus.res_addr)};
    for (int k = 0; k < 10; k++) begin
      n_checks++;
      if (got[k] !== 0) begin
        n_fail++;
        $display("FAIL reset_out%0d: got %0d exp 0", k, got[k]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    run_pass(0, -1, -1, -1);
    n_checks++;
    if (timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL nom_timeout: got 1 exp 0");
    end
    n_checks++;
    if (load_q.size() !== NN) begin
      n_fail++;
      $display("FAIL nom_loads: got %0d exp %0d", load_q.size(), NN);
    end
    for (int n = 0; n < NN && n < load_q.size(); n++) begin
      n_checks++;
      if (load_q[n] !== ld_cyc(n, 0) || ldb_q[n] !== n) begin
        n_fail++;
        $display("FAIL nom_load%0d: got cyc %0d b %0d exp cyc %0d b %0d",
                 n, load_q[n], ldb_q[n], ld_cyc(n, 0), n);
      end
    end
    n_checks++;
    if (iv_q.size() !== NN*NI) begin
      n_fail++;
      $display("FAIL nom_beats: got %0d exp %0d", iv_q.size(), NN*NI);
    end
    for (int k = 0; k < NN*NI && k < iv_q.size(); k++) begin
      n_checks++;
      if (iv_q[k] !== ld_cyc(k/NI, 0) + 2 + k%NI
          || wa_q[k] !== k || pa_q[k] !== k%NI
          || bias_q[k] !== int'(b_mem[k/NI])) begin
        n_fail++;
        $display("FAIL nom_beat%0d: got cyc %0d wa %0d pa %0d b %0h exp %0d %0d %0d %0h",
                 k, iv_q[k], wa_q[k], pa_q[k], bias_q[k],
                 ld_cyc(k/NI, 0) + 2 + k%NI, k, k%NI, b_mem[k/NI]);
      end
    end
    for (int n = 0; n < NN; n++) begin
      n_checks++;
      if (acc[n] !== ref_dot(n)) begin
        n_fail++;
        $display("FAIL nom_dot%0d: got %0h exp %0h", n, acc[n], ref_dot(n));
      end
    end
    n_checks++;
    if (we_q.size() !== NN) begin
      n_fail++;
      $display("FAIL nom_writes: got %0d exp %0d", we_q.size(), NN);
    end
    for (int n = 0; n < NN && n < we_q.size(); n++) begin
      n_checks++;
      if (we_q[n] !== ld_cyc(n, 0) + NI + 2 || ra_q[n] !== n
          || rd_q[n] !== int'(tok[n])) begin
        n_fail++;
        $display("FAIL nom_res%0d: got cyc %0d a %0d d %0h exp %0d %0d %0h",
                 n, we_q[n], ra_q[n], rd_q[n],
                 ld_cyc(n, 0) + NI + 2, n, tok[n]);
      end
    end
    n_checks++;
    if (done_q.size() !== 1 || done_q[0] !== ld_cyc(NN-1, 0) + NI + 3) begin
      n_fail++;
      $display("FAIL nom_done: got n %0d cyc %0d exp 1 cyc %0d",
               done_q.size(), done_q[0], ld_cyc(NN-1, 0) + NI + 3);
    end
  endtask

  task automatic test_start_in_stream();
    run_pass(0, 4, -1, -1);
    n_checks++;
    if (done_q.size() !== 1 || load_q.size() !== NN) begin
      n_fail++;
      $display("FAIL restart_count: got done %0d loads %0d exp 1 %0d",
               done_q.size(), load_q.size(), NN);
    end
    n_checks++;
    if (done_q[0] !== ld_cyc(NN-1, 0) + NI + 3) begin
      n_fail++;
      $display("FAIL restart_done: got %0d exp %0d",
               done_q[0], ld_cyc(NN-1, 0) + NI + 3);
    end
    n_checks++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_idle: got busy %0b exp 0", bus.busy);
    end
  endtask

  task automatic test_long_wait();
    run_pass(20, -1, -1, -1);
    n_checks++;
    if (iv_q.size() !== NN*NI || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_beats: got %0d exp %0d", iv_q.size(), NN*NI);
    end
    for (int k = 0; k < NN*NI && k < iv_q.size(); k++) begin
      n_checks++;
      if (iv_q[k] !== ld_cyc(k/NI, 20) + 2 + k%NI) begin
        n_fail++;
        $display("FAIL wait_beat%0d: got %0d exp %0d",
                 k, iv_q[k], ld_cyc(k/NI, 20) + 2 + k%NI);
      end
    end
    for (int n = 0; n < NN && n < we_q.size(); n++) begin
      n_checks++;
      if (we_q[n] !== ld_cyc(n, 20) + NI + 22 || rd_q[n] !== int'(tok[n])) begin
        n_fail++;
        $display("FAIL wait_res%0d: got cyc %0d d %0h exp %0d %0h",
                 n, we_q[n], rd_q[n], ld_cyc(n, 20) + NI + 22, tok[n]);
      end
    end
    n_checks++;
    if (done_q.size() !== 1 || done_q[0] !== ld_cyc(NN-1, 20) + NI + 23) begin
      n_fail++;
      $display("FAIL wait_done: got cyc %0d exp %0d",
               done_q[0], ld_cyc(NN-1, 20) + NI + 23);
    end
  endtask

  task automatic test_spurious();
    @(posedge clk); #1;
    bus.neuron_valid = 1'b1;
    bus.neuron_out = 16'h0123;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_checks++;
      if (bus.res_we !== 1'b0) begin
        n_fail++;
        $display("FAIL spur_idle%0d: got res_we %0b exp 0", k, bus.res_we);
      end
    end
    bus.neuron_valid = 1'b0;
    run_pass(0, -1, 3, -1);
    n_checks++;
    if (we_q.size() !== NN) begin
      n_fail++;
      $display("FAIL spur_writes: got %0d exp %0d", we_q.size(), NN);
    end
    for (int n = 0; n < NN && n < we_q.size(); n++) begin
      n_checks++;
      if (we_q[n] !== ld_cyc(n, 0) + NI + 2 || rd_q[n] !== int'(tok[n])) begin
        n_fail++;
        $display("FAIL spur_res%0d: got cyc %0d d %0h exp %0d %0h",
                 n, we_q[n], rd_q[n], ld_cyc(n, 0) + NI + 2, tok[n]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int got[9];
    run_pass(0, -1, -1, ld_cyc(1, 0) + 2);
    #1;
    got = '{int'(bus.busy), int'(bus.done),
            int'(bus.input_valid), int'(bus.neuron_clr),
            int'(bus.bias_in), int'(bus.pix_addr),
            int'(bus.w_addr), int'(bus.b_addr),
            int'(bus.res_addr)};
    for (int k = 0; k < 9; k++) begin
      n_checks++;
      if (got[k] !== 0) begin
        n_fail++;
        $display("FAIL abort_out%0d: got %0d exp 0", k, got[k]);
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_pass(0, -1, -1, -1);
    n_checks++;
    if (load_q.size() < 1 || load_q[0] !== 1 || ldb_q[0] !== 0) begin
      n_fail++;
      $display("FAIL abort_reload: got cyc %0d b %0d exp 1 0",
               load_q[0], ldb_q[0]);
    end
    for (int k = 0; k < NI && k < wa_q.size(); k++) begin
      n_checks++;
      if (wa_q[k] !== k || pa_q[k] !== k) begin
        n_fail++;
        $display("FAIL abort_addr%0d: got wa %0d pa %0d exp %0d",
                 k, wa_q[k], pa_q[k], k);
      end
    end
    for (int n = 0; n < NN; n++) begin
      n_checks++;
      if (acc[n] !== ref_dot(n)) begin
        n_fail++;
        $display("FAIL abort_dot%0d: got %0h exp %0h", n, acc[n], ref_dot(n));
      end
    end
    n_checks++;
    if (done_q.size() !== 1) begin
      n_fail++;
      $display("FAIL abort_done: got %0d exp 1", done_q.size());
    end
  endtask

  task automatic test_back_to_back();
    int d;
    for (int p = 0; p < 3; p++) begin
      d = int'($urandom_range(0, 4));
      run_pass(d, -1, -1, -1);
      n_checks++;
      if (timeout !== 1'b0 || done_q.size() !== 1
          || done_q[0] !== ld_cyc(NN-1, d) + NI + 3 + d) begin
        n_fail++;
        $display("FAIL b2b%0d_done: got n %0d cyc %0d exp 1 %0d",
                 p, done_q.size(), done_q[0], ld_cyc(NN-1, d) + NI + 3 + d);
      end
      for (int n = 0; n < NN && n < we_q.size(); n++) begin
        n_checks++;
        if (acc[n] !== ref_dot(n) || rd_q[n] !== int'(tok[n])
            || we_q[n] !== ld_cyc(n, d) + NI + 2 + d) begin
          n_fail++;
          $display("FAIL b2b%0d_n%0d: got dot %0h d %0h cyc %0d exp %0h %0h %0d",
                   p, n, acc[n], rd_q[n], we_q[n],
                   ref_dot(n), tok[n], ld_cyc(n, d) + NI + 2 + d);
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.neuron_valid = 1'b0;
    bus.neuron_out = '0;
    test_reset();
    test_nominal();
    test_start_in_stream();
    test_long_wait();
    test_spurious();
    test_reset_mid();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/layer_sequencer.md
LAYER_SEQUENCER -- requirements
Module: layer_sequencer

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16, pixel/weight/bias width (Q1.15).
REQ-002 SHALL have parameter NUM_INPUTS, default 784, inputs per neuron.
REQ-003 SHALL have parameter NUM_NEURONS, default 10, neurons per layer.
REQ-004 SHALL have parameter OUT_WIDTH, default 16, neuron result width.
REQ-005 SHALL have one clock and an asynchronous, active-high reset:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
REQ-006 SHALL have these ports:
- start  in  1  start one layer pass.
- busy  out  1  pass in progress.
- done  out  1  one-cycle end-of-pass pulse.
- pix_addr  out  clog2(NUM_INPUTS)  pixel RAM read address.
- pix_data  in  IN_WIDTH  pixel RAM read data.
- w_addr  out  clog2(NUM_INPUTS*NUM_NEURONS)  weight RAM read address.
- w_data  in  IN_WIDTH  weight RAM read data.
- b_addr  out  clog2(NUM_NEURONS)  bias RAM read address.
- b_data  in  IN_WIDTH  bias RAM read data.
- neuron_clr  out  1  synchronous clear to the neuron.
- data_in  out  IN_WIDTH  neuron pixel operand.
- weight_in  out  IN_WIDTH  neuron weight operand.
- bias_in  out  IN_WIDTH  neuron bias.
- input_valid  out  1  operand beat valid.
- neuron_out  in  OUT_WIDTH  neuron result.
- neuron_valid  in  1  neuron result valid.
- res_we  out  1  result write enable.
- res_addr  out  clog2(NUM_NEURONS)  result index.
- res_data  out  OUT_WIDTH  result value.

Function
REQ-007 SHALL implement states IDLE, LOAD, STREAM, WAIT, DONE.
REQ-008 SHALL treat all RAM ports as synchronous reads with data valid one cycle after the address.
REQ-009 SHALL, in IDLE with start=1, clear the neuron index n to 0 and enter LOAD; start SHALL be ignored in every other state.
REQ-010 SHALL, in LOAD (exactly one cycle), drive b_addr=n and neuron_clr=1, then enter STREAM with input counter i=0.
REQ-011 SHALL, in the first STREAM cycle, register b_data into bias_in; bias_in SHALL then stay stable until the next LOAD.
REQ-012 SHALL, in each STREAM cycle, drive pix_addr=i and w_addr=n*NUM_INPUTS+i and increment i; after the cycle issuing i=NUM_INPUTS-1 it SHALL enter WAIT.
REQ-013 SHALL generate input_valid as the issue strobe delayed one register stage:
- data_in is pix_data passed through combinationally.
- weight_in is w_data passed through combinationally.
- Result: exactly NUM_INPUTS contiguous input_valid beats per neuron, no gaps.
REQ-014 SHALL, in WAIT with neuron_valid=1, assert res_we combinationally with res_addr=n and res_data=neuron_out, then:
- enter DONE if n=NUM_NEURONS-1;
- otherwise increment n and enter LOAD.
REQ-015 SHALL ignore neuron_valid in any state other than WAIT (res_we=0).
REQ-016 SHALL hold done=1 for the single DONE cycle, then return to IDLE.
REQ-017 SHALL assert busy in every state except IDLE.
REQ-018 SHALL keep w_addr computation free of overflow for the maximum address NUM_INPUTS*NUM_NEURONS-1.
REQ-019 SHALL take NUM_INPUTS+3 cycles per neuron when neuron_valid arrives one cycle after the last beat; WAIT SHALL otherwise wait indefinitely.

Reset
REQ-020 SHALL, on rst, asynchronously set:
- state=IDLE, n=0, i=0;
- busy, done, input_valid, neuron_clr and res_we to 0;
- bias_in and all address outputs to 0.
REQ-021 SHALL abandon any pass in progress when rst is asserted; the next start SHALL restart from neuron 0 with neuron_clr asserted.

Structure
REQ-022 SHALL take the state encoding enum and the fixed-point width constants from shared package nn_pkg.
REQ-023 SHALL implement the i/n address counter pair as sub-module addr_gen (enable, wrap, last flags).

Verification
REQ-024 NUM_INPUTS=4, NUM_NEURONS=2, start at cycle 0, neuron_valid one cycle after each last beat -> LOAD at cycles 1 and 8; input_valid high at cycles 3-6 and 10-13; res_we at cycles 7 and 14; done at cycle 15.
REQ-025 w_addr trace in the test above -> 0,1,2,3 then 4,5,6,7; pix_addr -> 0,1,2,3 twice; bias_in=b_data[0], then b_data[1].
REQ-026 start pulsed during STREAM -> no effect; exactly one done pulse.
REQ-027 rst asserted mid-STREAM of neuron 1 -> all outputs 0 immediately; a subsequent start re-streams neuron 0 with neuron_clr=1.
REQ-028 neuron_valid held off 20 cycles in WAIT -> input_valid stays 0; res_we fires on the neuron_valid cycle with res_data=neuron_out (e.g. 16'h0123).
REQ-029 spurious neuron_valid in IDLE or STREAM -> res_we stays 0.
